// File: rtl/wb_master_if_pkg.sv
// Shared definitions for the Wishbone master interface: FSM state encoding,
// bus widths and the default transfer timeout.
package wb_master_if_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;
   localparam int CNT_W  = 8;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BUSY      = 2'd1,
      ST_WAIT_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/wb_master_if.sv
// Wishbone classic master bridging a stalling CPU load/store port onto the bus.
// One transfer at a time; every transfer ends with cyc low for at least one
// cycle so each request presents a fresh cyc&stb rising edge.
module wb_master_if
   import wb_master_if_pkg::*;
#(
   parameter int                TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter logic [DATA_W-1:0] RESET_DATA     = 32'h0000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   // CPU side
   input  logic              cpu_ce_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [SEL_W-1:0]  cpu_sel_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   output logic [DATA_W-1:0] cpu_data_o,
   input  logic              cpu_hold_i,
   input  logic              flush_i,
   output logic              stallreq_o,
   output logic              bus_err_o,
   // Bus side
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [SEL_W-1:0]  wb_sel_o,
   output logic [DATA_W-1:0] wb_data_o,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);

   // Counter value seen during the last permitted BUSY cycle (counter is 0 in the first).
   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [DATA_W-1:0]   rbuf_reg;
   logic                cyc_reg;
   logic                stb_reg;
   logic                we_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [SEL_W-1:0]    sel_reg;
   logic [DATA_W-1:0]   data_reg;
   logic                err_reg;

   logic busy;
   logic accept;
   logic timeout_hit;
   logic ack_read;

   assign busy        = (state_reg == ST_BUSY);
   assign accept      = (state_reg == ST_IDLE) && cpu_ce_i && !flush_i;
   assign timeout_hit = busy && (cnt_reg >= TIMEOUT_LIMIT);
   assign ack_read    = busy && wb_ack_i && !we_reg;

   // Stall while a request is being launched or is still outstanding on the bus;
   // the cycle that resolves the transfer releases the pipeline.
   assign stallreq_o = !wb_rst_i &&
                       (accept ||
                        (busy && !(wb_ack_i || wb_err_i || flush_i || timeout_hit)));

   // Read data is forwarded straight from the bus in the ack cycle so the CPU
   // can consume it without waiting for the buffer to update.
   assign cpu_data_o = ack_read ? wb_data_i : rbuf_reg;

   assign wb_cyc_o  = cyc_reg;
   assign wb_stb_o  = stb_reg;
   assign wb_we_o   = we_reg;
   assign wb_addr_o = addr_reg;
   assign wb_sel_o  = sel_reg;
   assign wb_data_o = data_reg;
   assign bus_err_o = err_reg;

   // Transfer FSM: launches requests, resolves ack/err/flush/timeout in priority
   // order flush > ack > err > timeout, and owns all registered outputs.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         rbuf_reg  <= RESET_DATA;
         cyc_reg   <= 1'b0;
         stb_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         sel_reg   <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  we_reg    <= cpu_we_i;
                  addr_reg  <= cpu_addr_i;
                  sel_reg   <= cpu_sel_i;
                  data_reg  <= cpu_data_i;
                  cyc_reg   <= 1'b1;
                  stb_reg   <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt_reg != CNT_MAX) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
               if (flush_i) begin
                  cyc_reg   <= 1'b0;
                  stb_reg   <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (wb_ack_i) begin
                  cyc_reg <= 1'b0;
                  stb_reg <= 1'b0;
                  if (!we_reg) begin
                     rbuf_reg <= wb_data_i;
                  end
                  state_reg <= cpu_hold_i ? ST_WAIT_HOLD : ST_IDLE;
               end else if (wb_err_i || timeout_hit) begin
                  cyc_reg   <= 1'b0;
                  stb_reg   <= 1'b0;
                  err_reg   <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            ST_WAIT_HOLD: begin
               if (!cpu_hold_i || flush_i) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_if.sv
// Scoreboard bench for wb_master_if: the driver computes each transfer's
// expected outcome from the interface rules and queues it; an independent
// monitor pops an entry whenever cyc rises and checks the bus-visible result.
module tb_wb_master_if;

   localparam int          T_CYC    = 16;
   localparam logic [31:0] RST_DATA = 32'hA5A5_0001;

   localparam int K_ACK       = 0;
   localparam int K_ERR       = 1;
   localparam int K_TMO       = 2;
   localparam int K_FLUSH     = 3;
   localparam int K_FLUSH_ACK = 4;
   localparam int K_ACK_ERR   = 5;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
      int          cycles;
      logic        err;
      logic        ack_chk;
      logic [31:0] ack_data;
      logic [31:0] buf_after;
      logic        end_stall;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          txn_no = 0;
   logic [31:0] model_buf;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic        cpu_ce_i;
   logic        cpu_we_i;
   logic [31:0] cpu_addr_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic        cpu_hold_i;
   logic        flush_i;
   logic        stallreq_o;
   logic        bus_err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_addr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_data_o;
   logic [31:0] wb_data_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   wb_master_if #(
      .TIMEOUT_CYCLES (T_CYC),
      .RESET_DATA     (RST_DATA)
   ) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .cpu_ce_i   (cpu_ce_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_sel_i  (cpu_sel_i),
      .cpu_data_i (cpu_data_i),
      .cpu_data_o (cpu_data_o),
      .cpu_hold_i (cpu_hold_i),
      .flush_i    (flush_i),
      .stallreq_o (stallreq_o),
      .bus_err_o  (bus_err_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_addr_o  (wb_addr_o),
      .wb_sel_o   (wb_sel_o),
      .wb_data_o  (wb_data_o),
      .wb_data_i  (wb_data_i),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %08h, required %08h", name, act, req);
      end
   endtask

   // One CPU transfer with a scripted slave response; expected outcome is queued first.
   task automatic run_txn(input int kind, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data, input int lat,
                          input logic [31:0] rdata, input int hold_n,
                          input bit flush_exit, input bit flush_req);
      exp_t e;
      bit   is_ack;
      bit   takes;
      int   hn;
      is_ack = (kind == K_ACK) || (kind == K_ACK_ERR) || (kind == K_FLUSH_ACK);
      takes  = (kind == K_ACK) || (kind == K_ACK_ERR);
      hn     = takes ? hold_n : 0;

      e.we        = we;
      e.addr      = addr;
      e.sel       = sel;
      e.data      = data;
      e.cycles    = (kind == K_TMO) ? T_CYC : lat;
      e.err       = (kind == K_ERR) || (kind == K_TMO);
      e.ack_chk   = takes && !we;
      e.ack_data  = rdata;
      if (takes && !we) model_buf = rdata;
      e.buf_after = model_buf;
      e.end_stall = 1'b0;
      exp_q.push_back(e);
      txn_no++;
      $display("txn %0d: kind=%0d we=%0b addr=%08h sel=%h wdata=%08h lat=%0d hold=%0d exp_err=%0b",
               txn_no, kind, we, addr, sel, data, e.cycles, hn, e.err);

      cpu_ce_i   = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_sel_i  = sel;
      cpu_data_i = data;
      if (flush_req) begin
         flush_i = 1'b1;
         @(negedge wb_clk_i);
         chk("flush_req_stall", {31'b0, stallreq_o}, 32'h0);
         @(posedge wb_clk_i); #1;
         flush_i = 1'b0;
      end
      @(negedge wb_clk_i);
      chk("req_cyc_stall", {30'b0, wb_cyc_o, stallreq_o}, 32'h1);
      @(posedge wb_clk_i); #1;
      cpu_ce_i   = 1'b0;
      cpu_we_i   = 1'($urandom_range(0, 1));
      cpu_addr_i = $urandom;
      cpu_sel_i  = 4'($urandom);
      cpu_data_i = $urandom;

      for (int k = 1; k <= e.cycles; k++) begin
         wb_data_i  = (is_ack && k == lat) ? rdata : $urandom;
         wb_ack_i   = is_ack && (k == lat);
         wb_err_i   = ((kind == K_ERR) || (kind == K_ACK_ERR)) && (k == lat);
         flush_i    = ((kind == K_FLUSH) || (kind == K_FLUSH_ACK)) && (k == lat);
         cpu_hold_i = takes && (hn > 0) && (k == lat);
         @(negedge wb_clk_i);
         if (k == 1) chk("accept", {31'b0, wb_cyc_o}, 32'h1);
         @(posedge wb_clk_i); #1;
      end
      wb_ack_i  = 1'b0;
      wb_err_i  = 1'b0;
      flush_i   = 1'b0;
      wb_data_i = $urandom;

      if (hn > 0) begin
         for (int j = 0; j < hn; j++) begin
            cpu_ce_i = 1'b1;
            @(negedge wb_clk_i);
            chk("hold_cyc_stall", {30'b0, wb_cyc_o, stallreq_o}, 32'h0);
            chk("hold_rdata", cpu_data_o, model_buf);
            @(posedge wb_clk_i); #1;
         end
         cpu_ce_i = 1'b0;
         if (flush_exit) flush_i = 1'b1;
         else            cpu_hold_i = 1'b0;
         @(posedge wb_clk_i); #1;
         flush_i = 1'b0;
      end
      cpu_hold_i = 1'b0;
   endtask

   // Reset pulsed in the third BUSY cycle, then a stray ack arrives.
   task automatic reset_mid_busy();
      exp_t e;
      e.we        = 1'b0;
      e.addr      = 32'h0000_0700;
      e.sel       = 4'hF;
      e.data      = 32'h1111_2222;
      e.cycles    = 3;
      e.err       = 1'b0;
      e.ack_chk   = 1'b0;
      e.ack_data  = '0;
      e.buf_after = RST_DATA;
      e.end_stall = 1'b1;
      model_buf   = RST_DATA;
      exp_q.push_back(e);
      txn_no++;
      $display("txn %0d: read addr=%08h with reset in BUSY cycle 3", txn_no, e.addr);

      cpu_ce_i   = 1'b1;
      cpu_we_i   = e.we;
      cpu_addr_i = e.addr;
      cpu_sel_i  = e.sel;
      cpu_data_i = e.data;
      @(posedge wb_clk_i); #1;
      cpu_ce_i = 1'b0;
      repeat (2) begin
         @(posedge wb_clk_i); #1;
      end
      @(negedge wb_clk_i); #2;
      wb_rst_i = 1'b1;
      #1;
      chk("rst_async_ctl", {27'b0, wb_cyc_o, wb_stb_o, wb_we_o, stallreq_o, bus_err_o}, 32'h0);
      chk("rst_async_addr", wb_addr_o, 32'h0);
      chk("rst_async_sel", {28'b0, wb_sel_o}, 32'h0);
      chk("rst_async_wdata", wb_data_o, 32'h0);
      chk("rst_async_rdata", cpu_data_o, RST_DATA);
      wb_ack_i  = 1'b1;
      wb_data_i = $urandom;
      @(posedge wb_clk_i); #1;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      chk("late_ack_ctl", {29'b0, wb_cyc_o, wb_stb_o, bus_err_o}, 32'h0);
      chk("late_ack_rdata", cpu_data_o, RST_DATA);
      @(posedge wb_clk_i); #1;
      wb_ack_i = 1'b0;
   endtask

   // Monitor: one queue entry per observed cyc high period.
   initial begin : monitor
      exp_t e;
      int   n;
      bit   bad_bus;
      bit   bad_stall;
      @(negedge wb_clk_i);
      forever begin
         if (!wb_cyc_o) begin
            @(negedge wb_clk_i);
            continue;
         end
         if (exp_q.size() == 0) begin
            chk("unexpected_cyc", {31'b0, wb_cyc_o}, 32'h0);
            n = 0;
            while (wb_cyc_o && n < 64) begin
               n++;
               @(negedge wb_clk_i);
            end
            continue;
         end
         e         = exp_q.pop_front();
         n         = 0;
         bad_bus   = 1'b0;
         bad_stall = 1'b0;
         while (wb_cyc_o && n < 64) begin
            n++;
            if (wb_stb_o !== 1'b1 || wb_we_o !== e.we || wb_addr_o !== e.addr ||
                wb_sel_o !== e.sel || wb_data_o !== e.data)
               bad_bus = 1'b1;
            if (stallreq_o !== ((n == e.cycles) ? e.end_stall : 1'b1))
               bad_stall = 1'b1;
            if (n == e.cycles && e.ack_chk)
               chk("ack_rdata", cpu_data_o, e.ack_data);
            @(negedge wb_clk_i);
         end
         chk("busy_len", n, e.cycles);
         chk("bus_stable", {31'b0, bad_bus}, 32'h0);
         chk("stall_busy", {31'b0, bad_stall}, 32'h0);
         chk("stb_low", {31'b0, wb_stb_o}, 32'h0);
         chk("err_pulse", {31'b0, bus_err_o}, {31'b0, e.err});
         chk("rbuf", cpu_data_o, e.buf_after);
         @(negedge wb_clk_i);
         chk("err_width", {31'b0, bus_err_o}, 32'h0);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1);
   end

   initial begin : driver
      int kind;
      wb_rst_i   = 1'b1;
      cpu_ce_i   = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 32'h0;
      cpu_sel_i  = 4'h0;
      cpu_data_i = 32'h0;
      cpu_hold_i = 1'b0;
      flush_i    = 1'b0;
      wb_data_i  = 32'h0;
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      model_buf  = RST_DATA;

      @(negedge wb_clk_i);
      chk("rst_ctl", {27'b0, wb_cyc_o, wb_stb_o, wb_we_o, stallreq_o, bus_err_o}, 32'h0);
      chk("rst_addr", wb_addr_o, 32'h0);
      chk("rst_sel", {28'b0, wb_sel_o}, 32'h0);
      chk("rst_wdata", wb_data_o, 32'h0);
      chk("rst_rdata", cpu_data_o, RST_DATA);
      cpu_ce_i = 1'b0;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      @(posedge wb_clk_i); #1;

      // Directed cases
      run_txn(K_ACK,       1'b0, 32'h0000_0100, 4'hF,    32'h5555_0000, 5,     32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      run_txn(K_ACK,       1'b1, 32'h0000_0200, 4'b0011, 32'h1234_5678, 4,     32'h7777_7777, 0, 1'b0, 1'b0);
      run_txn(K_FLUSH_ACK, 1'b0, 32'h0000_0300, 4'hF,    32'h0,         3,     32'hCAFE_F00D, 0, 1'b0, 1'b0);
      run_txn(K_TMO,       1'b0, 32'h0000_0400, 4'hF,    32'h0,         1,     32'h0,         0, 1'b0, 1'b0);
      run_txn(K_ACK,       1'b0, 32'h0000_0500, 4'hF,    32'h0,         2,     32'h0BAD_F00D, 3, 1'b0, 1'b0);
      run_txn(K_ACK,       1'b0, 32'h0000_0600, 4'hF,    32'h0,         1,     32'h1357_9BDF, 0, 1'b0, 1'b0);
      run_txn(K_ACK,       1'b0, 32'h0000_0604, 4'hF,    32'h0,         1,     32'h2468_ACE0, 0, 1'b0, 1'b0);
      run_txn(K_ACK_ERR,   1'b0, 32'h0000_0608, 4'hF,    32'h0,         T_CYC, 32'h0F0F_0F0F, 0, 1'b0, 1'b0);
      run_txn(K_ERR,       1'b1, 32'h0000_060C, 4'hC,    32'hAAAA_5555, T_CYC, 32'h0,         0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 5);
         run_txn(kind, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                 $urandom_range(1, T_CYC), $urandom, $urandom_range(0, 3),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) begin
            @(posedge wb_clk_i); #1;
         end
      end

      reset_mid_busy();
      run_txn(K_ACK, 1'b0, 32'h0000_0800, 4'hF, 32'h0, 3, 32'h8888_1234, 0, 1'b0, 1'b0);

      repeat (3) begin
         @(posedge wb_clk_i); #1;
      end
      chk("queue_empty", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
